// File: rtl/sys1_pause_dim.sv
// sys1_pause_dim
// Frame-synchronous user pause and screen dimming for SEGA System 1.
// The debounced pause button requests pause or resume. The request takes
// effect only at the start of vblank, so a frame is never torn. After a
// hold-off while paused, the picture fades down in steps, one step every
// FADE_FRAMES frames, until it reaches MAX_SHIFT. The hiscore pause request
// is merged into the core pause line but never changes state.
// Ports:
//   clk_sys    system clock
//   rst_n      asynchronous active-low reset
//   m_pause    pause button, active-high, synchronous to clk_sys
//   hs_pause   hiscore pause request, active-high
//   vblank     vertical blank from HVGEN, active-high
//   rgb_in     {r[2:0],g[2:0],b[1:0]} from HVGEN
//   rgb_out    dimmed colour to arcade_video, registered
//   pause_core user pause OR hs_pause, registered
//   dimmed     high while fully dimmed, registered
module sys1_pause_dim #(
    parameter logic [31:0] DIM_DELAY   = 32'd480_000_000,
    parameter int unsigned FADE_FRAMES = 4,
    parameter int unsigned MAX_SHIFT   = 1,
    parameter logic [23:0] LOCKOUT     = 24'd2_400_000
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       m_pause,
    input  logic       hs_pause,
    input  logic       vblank,
    input  logic [7:0] rgb_in,
    output logic [7:0] rgb_out,
    output logic       pause_core,
    output logic       dimmed
);

    typedef enum logic [2:0] {
        S_RUN          = 3'd0,
        S_PAUSE_PEND   = 3'd1,
        S_PAUSE_HOLD   = 3'd2,
        S_FADE         = 3'd3,
        S_DIM          = 3'd4,
        S_RESUME_PEND  = 3'd5
    } state_e;

    localparam logic [31:0] DIM_LAST  = DIM_DELAY - 32'd1;
    localparam logic [7:0]  FADE_LAST = 8'(FADE_FRAMES - 1);
    localparam logic [1:0]  MAX_LVL   = 2'(MAX_SHIFT);
    localparam logic [23:0] LOCK_LOAD = LOCKOUT - 24'd1;

    state_e      state_q, state_d;
    logic [1:0]  level_q, level_d;
    logic [31:0] timer_q, timer_d;
    logic [7:0]  fcnt_q, fcnt_d;
    logic [23:0] lock_q, lock_d;
    logic        m_pause_q;
    logic        vblank_q;
    logic [7:0]  rgb_out_q, rgb_out_d;
    logic        pause_core_q, pause_core_d;
    logic        dimmed_q, dimmed_d;

    logic        press_s;
    logic        vbs_s;
    logic        user_p_s;
    logic [1:0]  level_inc_s;

    // Edge detection: a press is ignored while the lockout window is open.
    assign press_s     = m_pause & ~m_pause_q & (lock_q == 24'd0);
    assign vbs_s       = vblank & ~vblank_q;
    assign level_inc_s = level_q + 2'd1;

    // Lockout window after an accepted press.
    always_comb begin
        lock_d = lock_q;
        if (press_s) begin
            lock_d = LOCK_LOAD;
        end else if (lock_q != 24'd0) begin
            lock_d = lock_q - 24'd1;
        end else begin
            lock_d = lock_q;
        end
    end

    // Pause/fade state machine; a press always wins over a vblank start.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        timer_d = timer_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            S_RUN: begin
                if (press_s) begin
                    state_d = S_PAUSE_PEND;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_PAUSE_PEND: begin
                if (press_s) begin
                    state_d = S_RUN;
                end else if (vbs_s) begin
                    state_d = S_PAUSE_HOLD;
                    timer_d = 32'd0;
                end else begin
                    state_d = S_PAUSE_PEND;
                end
            end
            S_PAUSE_HOLD: begin
                if (press_s) begin
                    state_d = S_RESUME_PEND;
                    level_d = 2'd0;
                end else if (timer_q == DIM_LAST) begin
                    state_d = S_FADE;
                    fcnt_d  = 8'd0;
                end else if (timer_q != 32'hFFFF_FFFF) begin
                    timer_d = timer_q + 32'd1;
                end else begin
                    timer_d = timer_q;
                end
            end
            S_FADE: begin
                if (press_s) begin
                    state_d = S_RESUME_PEND;
                    level_d = 2'd0;
                end else if (vbs_s) begin
                    if (fcnt_q == FADE_LAST) begin
                        fcnt_d  = 8'd0;
                        level_d = level_inc_s;
                        if (level_inc_s == MAX_LVL) begin
                            state_d = S_DIM;
                        end else begin
                            state_d = S_FADE;
                        end
                    end else begin
                        fcnt_d = fcnt_q + 8'd1;
                    end
                end else begin
                    state_d = S_FADE;
                end
            end
            S_DIM: begin
                if (press_s) begin
                    state_d = S_RESUME_PEND;
                    level_d = 2'd0;
                end else begin
                    state_d = S_DIM;
                end
            end
            S_RESUME_PEND: begin
                if (press_s) begin
                    state_d = S_PAUSE_HOLD;
                    timer_d = 32'd0;
                end else if (vbs_s) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_RESUME_PEND;
                end
            end
            default: begin
                state_d = S_RUN;
                level_d = 2'd0;
            end
        endcase
    end

    // Outputs follow the next state so picture, dim flag and pause line
    // all change on the same edge as the state itself.
    always_comb begin
        user_p_s     = (state_d == S_PAUSE_HOLD) || (state_d == S_FADE) ||
                       (state_d == S_DIM) || (state_d == S_RESUME_PEND);
        pause_core_d = user_p_s | hs_pause;
        dimmed_d     = (state_d == S_DIM);
        rgb_out_d    = {rgb_in[7:5] >> level_d, rgb_in[4:2] >> level_d,
                        rgb_in[1:0] >> level_d};
    end

    // State and output registers.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_RUN;
            level_q      <= 2'd0;
            timer_q      <= 32'd0;
            fcnt_q       <= 8'd0;
            lock_q       <= 24'd0;
            m_pause_q    <= 1'b0;
            vblank_q     <= 1'b0;
            rgb_out_q    <= 8'd0;
            pause_core_q <= 1'b0;
            dimmed_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            timer_q      <= timer_d;
            fcnt_q       <= fcnt_d;
            lock_q       <= lock_d;
            m_pause_q    <= m_pause;
            vblank_q     <= vblank;
            rgb_out_q    <= rgb_out_d;
            pause_core_q <= pause_core_d;
            dimmed_q     <= dimmed_d;
        end
    end

    assign rgb_out    = rgb_out_q;
    assign pause_core = pause_core_q;
    assign dimmed     = dimmed_q;

endmodule
